// File: rtl/race_control.sv
// race_control: start-light sequencer for the drag race. It runs the
// red/yellow/green countdown, detects false starts, finish and timeout, and
// drives the stopwatch restart/start controls.
module race_control #(
  parameter int unsigned LIGHT_MS   = 1000,
  parameter int unsigned TIMEOUT_MS = 30000
) (
  input  logic       clk1KHz,
  input  logic       reset,
  input  logic       go,
  input  logic       throttle,
  input  logic       finish,
  output logic       restart,
  output logic       start,
  output logic [2:0] lights,
  output logic [2:0] race_state,
  output logic       false_start,
  output logic       race_done,
  output logic       timed_out
);

  localparam int unsigned CW = 20;
  localparam logic [CW-1:0] LIGHT_LAST   = CW'(LIGHT_MS - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_MS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RED    = 3'd1,
    YELLOW = 3'd2,
    GREEN  = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [CW-1:0]   cnt;
  logic            nxt_timed_out;
  logic            nxt_restart;
  logic            nxt_start;
  logic [2:0]      nxt_lights;
  logic            nxt_false_start;
  logic            nxt_race_done;

  // Next-state selection and decode of the registered outputs for that state
  always_comb begin
    nxt_state       = state;
    nxt_timed_out   = 1'b0;
    nxt_restart     = 1'b0;
    nxt_start       = 1'b0;
    nxt_lights      = 3'b000;
    nxt_false_start = 1'b0;
    nxt_race_done   = 1'b0;

    case (state)
      IDLE, FAULT: begin
        if (go) nxt_state = RED;
      end
      DONE: begin
        if (go) nxt_state = RED;
        else    nxt_timed_out = timed_out;
      end
      RED: begin
        if (throttle)                nxt_state = FAULT;
        else if (cnt == LIGHT_LAST)  nxt_state = YELLOW;
      end
      YELLOW: begin
        if (throttle)                nxt_state = FAULT;
        else if (cnt == LIGHT_LAST)  nxt_state = GREEN;
      end
      GREEN: begin
        if (finish) begin
          nxt_state = DONE;
        end else if (cnt == TIMEOUT_LAST) begin
          nxt_state     = DONE;
          nxt_timed_out = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase

    case (nxt_state)
      RED: begin
        nxt_lights  = 3'b100;
        nxt_restart = (state != RED);
      end
      YELLOW: nxt_lights = 3'b010;
      GREEN: begin
        nxt_lights = 3'b001;
        nxt_start  = 1'b1;
      end
      DONE: begin
        nxt_lights    = 3'b001;
        nxt_race_done = 1'b1;
      end
      FAULT: begin
        nxt_lights      = 3'b100;
        nxt_false_start = 1'b1;
      end
      default: nxt_lights = 3'b000;
    endcase
  end

  // State, phase counter (cleared on every state entry) and output registers
  always_ff @(posedge clk1KHz) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      restart     <= 1'b0;
      start       <= 1'b0;
      lights      <= 3'b000;
      race_state  <= 3'd0;
      false_start <= 1'b0;
      race_done   <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state <= nxt_state;
      if (nxt_state != state)
        cnt <= '0;
      else if (state == RED || state == YELLOW || state == GREEN)
        cnt <= cnt + CW'(1);
      restart     <= nxt_restart;
      start       <= nxt_start;
      lights      <= nxt_lights;
      race_state  <= 3'(nxt_state);
      false_start <= nxt_false_start;
      race_done   <= nxt_race_done;
      timed_out   <= nxt_timed_out;
    end
  end

endmodule

// File: tb/tb_race_control.sv
// Directed bench for race_control with LIGHT_MS=4, TIMEOUT_MS=10.
module tb_race_control;

  logic       clk1KHz = 1'b0;
  logic       reset   = 1'b1;
  logic       go      = 1'b0;
  logic       throttle = 1'b0;
  logic       finish  = 1'b0;
  logic       restart;
  logic       start;
  logic [2:0] lights;
  logic [2:0] race_state;
  logic       false_start;
  logic       race_done;
  logic       timed_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned sw = 0;

  race_control #(.LIGHT_MS(4), .TIMEOUT_MS(10)) dut (
    .clk1KHz    (clk1KHz),
    .reset      (reset),
    .go         (go),
    .throttle   (throttle),
    .finish     (finish),
    .restart    (restart),
    .start      (start),
    .lights     (lights),
    .race_state (race_state),
    .false_start(false_start),
    .race_done  (race_done),
    .timed_out  (timed_out)
  );

  always #5 clk1KHz = ~clk1KHz;

  // Stopwatch model fed by the controller outputs
  always @(posedge clk1KHz) begin
    if (restart)    sw <= 0;
    else if (start) sw <= sw + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Fields packed as {race_state, lights, restart, start, false_start, race_done, timed_out}
  task automatic expect_out(input string tag, input logic [2:0] st, input logic [2:0] li,
                            input bit rs, input bit sa, input bit fs, input bit dn, input bit to);
    chk(tag, {21'd0, race_state, lights, restart, start, false_start, race_done, timed_out},
             {21'd0, st, li, rs, sa, fs, dn, to});
  endtask

  task automatic tick();
    @(negedge clk1KHz);
  endtask

  // Go pulse then full countdown, ending in the first GREEN cycle
  task automatic lights_seq(input bit go_in_red);
    go = 1'b1;
    tick();
    go = 1'b0;
    expect_out("red1", 3'd1, 3'b100, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++) begin
      go = go_in_red && (i == 3);
      tick();
      go = 1'b0;
      if (i <= 4) expect_out("red", 3'd1, 3'b100, 0, 0, 0, 0, 0);
      else        expect_out("yellow", 3'd2, 3'b010, 0, 0, 0, 0, 0);
    end
    tick();
    expect_out("green1", 3'd3, 3'b001, 0, 1, 0, 0, 0);
  endtask

  initial begin
    // reset held two cycles, then idle
    tick();
    tick();
    expect_out("reset", 3'd0, 3'b000, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("idle", 3'd0, 3'b000, 0, 0, 0, 0, 0);
    end

    // normal race, finish sampled at end of 7th GREEN cycle
    lights_seq(1'b0);
    for (int i = 2; i <= 7; i++) begin
      tick();
      expect_out("green", 3'd3, 3'b001, 0, 1, 0, 0, 0);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    expect_out("done_fin", 3'd4, 3'b001, 0, 0, 0, 1, 0);
    chk("sw_fin", sw, 7);
    tick();
    expect_out("done_hold", 3'd4, 3'b001, 0, 0, 0, 1, 0);

    // false start in the 2nd YELLOW cycle, from DONE
    go = 1'b1;
    tick();
    go = 1'b0;
    expect_out("fs_red1", 3'd1, 3'b100, 1, 0, 0, 0, 0);
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (i <= 4) expect_out("fs_red", 3'd1, 3'b100, 0, 0, 0, 0, 0);
      else        expect_out("fs_yellow", 3'd2, 3'b010, 0, 0, 0, 0, 0);
    end
    throttle = 1'b1;
    tick();
    throttle = 1'b0;
    expect_out("fault", 3'd5, 3'b100, 0, 0, 1, 0, 0);
    tick();
    expect_out("fault_hold", 3'd5, 3'b100, 0, 0, 1, 0, 0);
    chk("sw_fault", sw, 0);

    // timeout: GREEN lasts exactly 10 cycles
    lights_seq(1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      expect_out("green_to", 3'd3, 3'b001, 0, 1, 0, 0, 0);
    end
    tick();
    expect_out("done_to", 3'd4, 3'b001, 0, 0, 0, 1, 1);
    chk("sw_to", sw, 10);
    tick();
    expect_out("done_to_hold", 3'd4, 3'b001, 0, 0, 0, 1, 1);

    // finish on the 10th GREEN cycle beats timeout
    lights_seq(1'b0);
    for (int i = 2; i <= 10; i++) begin
      tick();
      expect_out("green_tie", 3'd3, 3'b001, 0, 1, 0, 0, 0);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    expect_out("done_tie", 3'd4, 3'b001, 0, 0, 0, 1, 0);
    chk("sw_tie", sw, 10);

    // go during RED ignored; reset in 3rd GREEN cycle
    lights_seq(1'b1);
    for (int i = 2; i <= 3; i++) begin
      tick();
      expect_out("green_rst", 3'd3, 3'b001, 0, 1, 0, 0, 0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("mid_reset", 3'd0, 3'b000, 0, 0, 0, 0, 0);
    tick();
    expect_out("post_reset", 3'd0, 3'b000, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
